// File: rtl/decode_e_reg.sv
// Y86-64 decode stage plus E pipeline register.
// Derives source/destination register IDs from the D fields, drives the
// register-file read addresses, forwards operands from E/M/W, flags
// load-use hazards and latches the decoded instruction into E. A bubble
// is inserted on reset, on an external request or on a load-use hazard.
// Optional build macro: HAZARD_COUNT_EN adds lu_count/bub_count counters.
module decode_e_reg #(
  parameter int          W     = 64,
  parameter logic [3:0]  RNONE = 4'hF,
  parameter logic [3:0]  RRSP  = 4'h4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   d_stat,
  input  logic [3:0]   d_icode,
  input  logic [3:0]   d_ifun,
  input  logic [3:0]   d_rA,
  input  logic [3:0]   d_rB,
  input  logic [W-1:0] d_valC,
  input  logic [W-1:0] d_valP,
  output logic [3:0]   rf_srcA,
  output logic [3:0]   rf_srcB,
  input  logic [W-1:0] rf_rvalA,
  input  logic [W-1:0] rf_rvalB,
  input  logic [3:0]   e_dstE,
  input  logic [W-1:0] e_valE,
  input  logic [3:0]   m_dstE,
  input  logic [3:0]   m_dstM,
  input  logic [W-1:0] m_valE,
  input  logic [W-1:0] m_valM,
  input  logic [3:0]   w_dstE,
  input  logic [3:0]   w_dstM,
  input  logic [W-1:0] w_valE,
  input  logic [W-1:0] w_valM,
  input  logic         e_bubble_in,
  output logic         load_use,
  output logic [2:0]   E_stat,
  output logic [3:0]   E_icode,
  output logic [3:0]   E_ifun,
  output logic [W-1:0] E_valC,
  output logic [W-1:0] E_valA,
  output logic [W-1:0] E_valB,
  output logic [3:0]   E_dstE,
  output logic [3:0]   E_dstM,
  output logic [3:0]   E_srcA,
  output logic [3:0]   E_srcB
`ifdef HAZARD_COUNT_EN
  ,
  output logic [31:0]  lu_count,
  output logic [31:0]  bub_count
`endif
);

  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [2:0] S_AOK    = 3'b001;

  logic [3:0]   src_a, src_b, dst_e, dst_m;
  logic [W-1:0] val_a, val_b;
  logic         bubble;

  // Register ID decode from the D-stage instruction code.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (d_icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = d_rA;
      I_RET, I_POPQ:                      src_a = RRSP;
      default:                            src_a = RNONE;
    endcase
    case (d_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = d_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     src_b = RRSP;
      default:                            src_b = RNONE;
    endcase
    case (d_icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:          dst_e = d_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     dst_e = RRSP;
      default:                            dst_e = RNONE;
    endcase
    case (d_icode)
      I_MRMOVQ, I_POPQ:                   dst_m = d_rA;
      default:                            dst_m = RNONE;
    endcase
  end

  assign rf_srcA = src_a;
  assign rf_srcB = src_b;

  // Operand A: valP for jXX/call, else youngest forwarding source wins.
  // RNONE on the source side never matches, so RNONE destinations are never forwarded.
  always_comb begin
    val_a = rf_rvalA;
    if (d_icode == I_JXX || d_icode == I_CALL) val_a = d_valP;
    else if (src_a == RNONE)                   val_a = rf_rvalA;
    else if (src_a == e_dstE)                  val_a = e_valE;
    else if (src_a == m_dstM)                  val_a = m_valM;
    else if (src_a == m_dstE)                  val_a = m_valE;
    else if (src_a == w_dstM)                  val_a = w_valM;
    else if (src_a == w_dstE)                  val_a = w_valE;
  end

  // Operand B: same forwarding chain without the valP override.
  always_comb begin
    val_b = rf_rvalB;
    if (src_b == RNONE)                        val_b = rf_rvalB;
    else if (src_b == e_dstE)                  val_b = e_valE;
    else if (src_b == m_dstM)                  val_b = m_valM;
    else if (src_b == m_dstE)                  val_b = m_valE;
    else if (src_b == w_dstM)                  val_b = w_valM;
    else if (src_b == w_dstE)                  val_b = w_valE;
  end

  // Load in E whose destination is read by the instruction in D.
  always_comb begin
    load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
               (E_dstM != RNONE) &&
               ((E_dstM == src_a) || (E_dstM == src_b));
  end

  assign bubble = e_bubble_in || load_use;

  // E pipeline register: reset and bubble both load a nop.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      E_stat  <= S_AOK;
      E_icode <= I_NOP;
      E_ifun  <= 4'h0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else begin
      E_stat  <= d_stat;
      E_icode <= d_icode;
      E_ifun  <= d_ifun;
      E_valC  <= d_valC;
      E_valA  <= val_a;
      E_valB  <= val_b;
      E_dstE  <= dst_e;
      E_dstM  <= dst_m;
      E_srcA  <= src_a;
      E_srcB  <= src_b;
    end
  end

`ifdef HAZARD_COUNT_EN
  // Hazard statistics; a mispredict coinciding with a load-use counts once.
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_count  <= '0;
      bub_count <= '0;
    end else begin
      if (load_use) lu_count  <= lu_count + 32'd1;
      if (bubble)   bub_count <= bub_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/decode_e_reg.md
Name: decode_e_reg

Overview:
- Decode stage plus E pipeline register of the pipelined Y86-64 core. Sits between d_reg and execute.
- Derives source and destination register IDs from the D-register fields and drives the register-file read addresses.
- Selects forwarded operands for valA/valB, detects load-use hazards, and latches the result into the E register with bubble insertion.

Parameters:
- W, 64, datapath width.
- RNONE, 4'hF, "no register" ID.
- RRSP, 4'h4, stack pointer ID.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous active-high reset.
- d_stat  in  3  D status, one-hot |HLT|INS|AOK| (AOK=3'b001, INS=3'b010, HLT=3'b100).
- d_icode, d_ifun  in  4 each  D instruction code and function.
- d_rA, d_rB  in  4 each  D register specifiers.
- d_valC, d_valP  in  W each  D constant and next PC.
- rf_srcA, rf_srcB  out  4 each  register-file read addresses (combinational).
- rf_rvalA, rf_rvalB  in  W each  register-file read data (combinational).
- e_dstE  in  4; e_valE  in  W  execute-stage result (cnd-adjusted dstE).
- m_dstE, m_dstM  in  4 each; m_valE, m_valM  in  W each  memory-stage results.
- w_dstE, w_dstM  in  4 each; w_valE, w_valM  in  W each  writeback-stage results.
- e_bubble_in  in  1  external bubble request (branch mispredict).
- load_use  out  1  combinational hazard flag; pipeline control stalls F/D with it.
- E_stat  out  3; E_icode, E_ifun  out  4 each.
- E_valC, E_valA, E_valB  out  W each.
- E_dstE, E_dstM, E_srcA, E_srcB  out  4 each.

Behaviour:
- Codes: halt 0, nop 1, rrmovq/cmov 2, irmovq 3, rmmovq 4, mrmovq 5, OPq 6, jXX 7, call 8, ret 9, pushq A, popq B.
- srcA: icode {2,4,6,A} -> d_rA; {9,B} -> RRSP; else RNONE.
- srcB: icode {4,5,6} -> d_rB; {8,9,A,B} -> RRSP; else RNONE.
- dstE: icode {2,3,6} -> d_rB; {8,9,A,B} -> RRSP; else RNONE.
- dstM: icode {5,B} -> d_rA; else RNONE.
- rf_srcA = srcA and rf_srcB = srcB, combinational.
- valA selection, first match wins:
  1. icode {7,8} -> d_valP.
  2. srcA==e_dstE -> e_valE.
  3. srcA==m_dstM -> m_valM.
  4. srcA==m_dstE -> m_valE.
  5. srcA==w_dstM -> w_valM.
  6. srcA==w_dstE -> w_valE.
  7. Otherwise rf_rvalA.
- valB selection: same chain without the valP rule.
- A source equal to RNONE never matches a forwarding destination; RNONE destinations are never forwarded.
- load_use = (E_icode in {5,B}) && (E_dstM != RNONE) && (E_dstM == srcA || E_dstM == srcB). Evaluated from the current E register contents and the current D fields.
- Register update on every rising edge, priority order:
  1. rst -> bubble.
  2. e_bubble_in || load_use -> bubble.
  3. Otherwise load the decoded values.
- Bubble: E_stat=3'b001, E_icode=4'h1, E_ifun=0, E_valC/E_valA/E_valB=0, all four register IDs = RNONE.
- Latency: one cycle, D fields to E outputs.
- All E outputs take bubble values during reset; load_use is 0 after reset.
- Non-AOK d_stat still propagates to E_stat unchanged; no special handling here.
- Reset asserted mid-stream overrides bubble and load.
- A load-use bubble lasts exactly one cycle. The next cycle E holds a nop, so load_use deasserts and the stalled instruction decodes with the value forwarded from m_valM.

Optional Feature:
- Macro HAZARD_COUNT_EN.
- When defined, adds two outputs: lu_count [31:0] and bub_count [31:0].
  - lu_count increments on each clock edge where load_use=1.
  - bub_count increments on each edge where e_bubble_in=1 or load_use=1 (a simultaneous event counts once).
  - Both are cleared by rst and wrap at 2^32-1 -> 0.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- rst high for 2 cycles with arbitrary D inputs -> E_icode=1, E_stat=3'b001, E_dstE=E_dstM=E_srcA=E_srcB=4'hF, E_valA=0, load_use=0.
- D = OPq rA=2 rB=3, rf_rvalA=5, rf_rvalB=7, no forwarding -> next cycle E_valA=5, E_valB=7, E_dstE=3, E_srcA=2, E_srcB=3.
- Same OPq with e_dstE=2 e_valE=100, m_dstE=2 m_valE=200, w_dstM=3 w_valM=300 -> E_valA=100 (execute has priority), E_valB=300.
- E holds mrmovq (E_icode=5, E_dstM=2) while D = OPq rA=2 -> load_use=1; next edge E is a bubble. Then with m_dstM=2 m_valM=42 the OPq latches E_valA=42.
- D = call, d_valP=0x40, e_bubble_in=0 -> E_valA=0x40, E_srcB=E_dstE=4. Repeat with e_bubble_in=1 -> E bubble.
- With HAZARD_COUNT_EN: 3 load-use cycles plus 2 mispredict cycles, one of them coinciding with a load-use -> lu_count=3, bub_count=4; rst clears both to 0.
